wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back stage and architectural register file of the 8-bit pipelined core.
- Sits directly downstream of the MEM/WB pipeline register and consumes its WB_* outputs.
- Selects the write-back value (memory data or ALU result) and commits it to the register file.
- Serves two combinational read ports to the ID stage, with write-through bypass, and exports commit status and counters.

Parameters:
- NREGS, 8, number of architectural registers (power of two, 2..256)
- DW, 8, data width of registers and write-back values
- AW, 8, width of register address inputs (as carried by the pipeline)
- CW, 16, width of the commit counter

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- WB_mem_data  in  DW  load data from MEM/WB register
- WB_aluout  in  DW  ALU result from MEM/WB register
- WB_reg_write_addr  in  AW  destination register index
- WB_RegWrite  in  1  write enable for this instruction
- WB_MemtoReg  in  1  1 = write WB_mem_data, 0 = write WB_aluout
- ID_rs1_addr  in  AW  read port 1 index
- ID_rs2_addr  in  AW  read port 2 index
- ID_rs1_data  out  DW  read port 1 data (combinational)
- ID_rs2_data  out  DW  read port 2 data (combinational)
- wb_data  out  DW  selected write-back value (combinational, for EX forwarding)
- wb_fire  out  1  registered: a commit happened on the previous edge
- wb_count  out  CW  registered commit counter
- wb_err  out  1  registered sticky flag: write attempted to index >= NREGS

Behaviour:
- Reset: on a rising clk edge with rst_n=0, all NREGS registers clear to 0, wb_fire=0, wb_count=0, wb_err=0. Reset overrides any simultaneous write.
- wb_data = WB_MemtoReg ? WB_mem_data : WB_aluout, purely combinational, independent of WB_RegWrite.
- Commit condition: rst_n=1 and WB_RegWrite=1 and WB_reg_write_addr < NREGS. On the edge, reg[addr] <= wb_data. Latency is one edge; the value is visible in the array from the next cycle.
- Out-of-range write: WB_RegWrite=1 and addr >= NREGS. No array change, wb_fire=0 next cycle, and wb_err set to 1 (cleared only by reset).
- wb_fire <= commit condition, every edge.
- wb_count increments by 1 per commit and saturates at all-ones (no wrap).
- Read ports, each independent:
  - If rs addr >= NREGS, data = 0.
  - Else if the commit condition is true this cycle and WB_reg_write_addr == rs addr, data = wb_data (write-through bypass).
  - Else data = reg[rs addr].
- Both ports reading the same index return identical data, including under bypass.
- While rst_n=0, bypass is suppressed; reads return stored contents.
- No internal stall or handshake. A write is taken every cycle WB_RegWrite is high. A bubble is WB_RegWrite=0.

Optional Feature:
- Macro: WB_REGFILE_R0_ZERO_EN.
- Defined: register 0 is hardwired to zero.
  - Writes targeting index 0 are discarded: no array change, wb_fire=0, wb_count unchanged, wb_err unaffected.
  - Reads of index 0 return 0, with no bypass.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset then read all indices -> every ID_rsX_data=0, wb_count=0, wb_err=0, wb_fire=0.
- Write r3: RegWrite=1, MemtoReg=0, aluout=0x5A, mem_data=0xC3 -> ID_rs1_data(r3)=0x5A the same cycle via bypass, 0x5A next cycle from the array. wb_fire=1 and wb_count=1 after the edge. Repeat with MemtoReg=1 -> 0xC3.
- Write addr=0x08 with NREGS=8 and data 0x77 -> no register changes, wb_err=1 and stays 1 through 10 further cycles. ID read of 0x08 returns 0.
- Simultaneous rst_n=0 and write r5=0xFF -> r5=0 after the edge, wb_count=0. During the reset cycle, rs1=r5 returns the stored value, not 0xFF.
- Drive 65540 consecutive commits with CW=16 -> wb_count saturates at 0xFFFF.
- With WB_REGFILE_R0_ZERO_EN, write r0=0x12 -> read r0=0, wb_count unchanged. Without the macro, read r0=0x12.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile -- write-back stage and architectural register file of the
// 8-bit pipelined core.
//
// Takes the WB_* outputs of the MEM/WB pipeline register, selects the
// write-back value (load data or ALU result) and commits it to the register
// file. It also serves two combinational read ports to the ID stage, with
// write-through bypass, and exports commit status and a commit counter.
//
// Optional feature macro: WB_REGFILE_R0_ZERO_EN
//   defined   : register 0 is hardwired to zero. Writes to index 0 are
//               discarded, and reads of index 0 return 0 with no bypass.
//   undefined : register 0 is an ordinary register.
//
// Ports:
//   clk               in   system clock, all state updates on rising edge
//   rst_n             in   synchronous active-low reset
//   WB_mem_data       in   [DW] load data
//   WB_aluout         in   [DW] ALU result
//   WB_reg_write_addr in   [AW] destination register index
//   WB_RegWrite       in   write enable for this instruction
//   WB_MemtoReg       in   1 = write WB_mem_data, 0 = write WB_aluout
//   ID_rs1_addr       in   [AW] read port 1 index
//   ID_rs2_addr       in   [AW] read port 2 index
//   ID_rs1_data       out  [DW] read port 1 data (combinational)
//   ID_rs2_data       out  [DW] read port 2 data (combinational)
//   wb_data           out  [DW] selected write-back value (combinational)
//   wb_fire           out  a commit happened on the previous edge
//   wb_count          out  [CW] saturating commit counter
//   wb_err            out  sticky flag: write attempted to index >= NREGS
module wb_regfile #(
  parameter int NREGS = 8,
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] WB_mem_data,
  input  logic [DW-1:0] WB_aluout,
  input  logic [AW-1:0] WB_reg_write_addr,
  input  logic          WB_RegWrite,
  input  logic          WB_MemtoReg,
  input  logic [AW-1:0] ID_rs1_addr,
  input  logic [AW-1:0] ID_rs2_addr,
  output logic [DW-1:0] ID_rs1_data,
  output logic [DW-1:0] ID_rs2_data,
  output logic [DW-1:0] wb_data,
  output logic          wb_fire,
  output logic [CW-1:0] wb_count,
  output logic          wb_err
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
  // One extra bit so NREGS itself is representable even when NREGS == 2**AW.
  localparam logic [AW:0] NREGS_EXT = (AW+1)'(NREGS);

`ifdef WB_REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [DW-1:0] regs [NREGS];

  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rs1_idx;
  logic [IW-1:0] rs2_idx;
  logic          wr_in_range;
  logic          rs1_in_range;
  logic          rs2_in_range;
  logic          wr_to_r0;
  logic          commit;
  logic          wr_oob;

  // Range checks use the full address width; only then are the low bits
  // trusted as an array index.
  assign wr_idx       = WB_reg_write_addr[IW-1:0];
  assign rs1_idx      = ID_rs1_addr[IW-1:0];
  assign rs2_idx      = ID_rs2_addr[IW-1:0];
  assign wr_in_range  = {1'b0, WB_reg_write_addr} < NREGS_EXT;
  assign rs1_in_range = {1'b0, ID_rs1_addr} < NREGS_EXT;
  assign rs2_in_range = {1'b0, ID_rs2_addr} < NREGS_EXT;

  assign wb_data  = WB_MemtoReg ? WB_mem_data : WB_aluout;
  assign wr_to_r0 = R0_ZERO && (wr_idx == '0);

  // A discarded write to a hardwired r0 is neither a commit nor an error.
  assign commit = rst_n && WB_RegWrite && wr_in_range && !wr_to_r0;
  assign wr_oob = rst_n && WB_RegWrite && !wr_in_range;

  // commit already implies the write index is in range, so comparing the
  // low index bits is enough for the bypass match. commit is low during
  // reset, so reads then return stored contents.
  always_comb begin
    ID_rs1_data = '0;
    if (rs1_in_range) begin
      if (R0_ZERO && (rs1_idx == '0)) begin
        ID_rs1_data = '0;
      end else if (commit && (wr_idx == rs1_idx)) begin
        ID_rs1_data = wb_data;
      end else begin
        ID_rs1_data = regs[rs1_idx];
      end
    end
  end

  always_comb begin
    ID_rs2_data = '0;
    if (rs2_in_range) begin
      if (R0_ZERO && (rs2_idx == '0)) begin
        ID_rs2_data = '0;
      end else if (commit && (wr_idx == rs2_idx)) begin
        ID_rs2_data = wb_data;
      end else begin
        ID_rs2_data = regs[rs2_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      wb_fire  <= 1'b0;
      wb_count <= '0;
      wb_err   <= 1'b0;
    end else begin
      if (commit) begin
        regs[wr_idx] <= wb_data;
      end
      wb_fire <= commit;
      if (commit && (wb_count != '1)) begin
        wb_count <= wb_count + CW'(1);
      end
      if (wr_oob) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile. Stimulus pushes the expected response of every
// cycle into a queue; a monitor on the falling edge pops and compares.
module tb_wb_regfile;

  localparam int NREGS = 8;
  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;

`ifdef WB_REGFILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] WB_mem_data = '0;
  logic [DW-1:0] WB_aluout = '0;
  logic [AW-1:0] WB_reg_write_addr = '0;
  logic          WB_RegWrite = 1'b0;
  logic          WB_MemtoReg = 1'b0;
  logic [AW-1:0] ID_rs1_addr = '0;
  logic [AW-1:0] ID_rs2_addr = '0;
  logic [DW-1:0] ID_rs1_data;
  logic [DW-1:0] ID_rs2_data;
  logic [DW-1:0] wb_data;
  logic          wb_fire;
  logic [CW-1:0] wb_count;
  logic          wb_err;

  wb_regfile #(.NREGS(NREGS), .DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .WB_mem_data(WB_mem_data),
    .WB_aluout(WB_aluout),
    .WB_reg_write_addr(WB_reg_write_addr),
    .WB_RegWrite(WB_RegWrite),
    .WB_MemtoReg(WB_MemtoReg),
    .ID_rs1_addr(ID_rs1_addr),
    .ID_rs2_addr(ID_rs2_addr),
    .ID_rs1_data(ID_rs1_data),
    .ID_rs2_data(ID_rs2_data),
    .wb_data(wb_data),
    .wb_fire(wb_fire),
    .wb_count(wb_count),
    .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] wbd;
    logic [31:0] fire;
    logic [31:0] cnt;
    logic [31:0] err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: architectural contents and status as plain integers.
  int m_regs[NREGS];
  int m_fire;
  int m_count;
  int m_err;

  task automatic check(input string tag, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
    m_fire  = 0;
    m_count = 0;
    m_err   = 0;
  endfunction

  function automatic bit model_commits(input bit rst, input bit we, input int wa);
    return rst && we && (wa < NREGS) && !(R0Z && wa == 0);
  endfunction

  function automatic int model_read(input int a, input bit rst, input bit we,
                                    input int wa, input int wbv);
    if (a >= NREGS) return 0;
    if (R0Z && a == 0) return 0;
    if (model_commits(rst, we, wa) && wa == a) return wbv;
    return m_regs[a];
  endfunction

  // One clock cycle: drive inputs, queue the expected response, advance model.
  task automatic step(input string tag, input bit rst, input bit we, input bit mtr,
                      input int mem, input int alu, input int wa,
                      input int a1, input int a2);
    exp_t e;
    int   wbv;
    @(posedge clk);
    #1;
    rst_n             = rst;
    WB_RegWrite       = we;
    WB_MemtoReg       = mtr;
    WB_mem_data       = DW'(mem);
    WB_aluout         = DW'(alu);
    WB_reg_write_addr = AW'(wa);
    ID_rs1_addr       = AW'(a1);
    ID_rs2_addr       = AW'(a2);
    wbv = mtr ? (mem & 'hFF) : (alu & 'hFF);
    e.tag  = tag;
    e.rs1  = model_read(a1, rst, we, wa, wbv);
    e.rs2  = model_read(a2, rst, we, wa, wbv);
    e.wbd  = wbv;
    e.fire = m_fire;
    e.cnt  = m_count;
    e.err  = m_err;
    q.push_back(e);
    if (!rst) begin
      model_reset();
    end else begin
      if (model_commits(rst, we, wa)) begin
        m_regs[wa] = wbv;
        if (m_count < CMAX) m_count++;
      end
      m_fire = model_commits(rst, we, wa);
      if (we && wa >= NREGS) m_err = 1;
    end
  endtask

  function automatic int rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 19) return 255;
    return r % 16;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check(mon_e.tag, "rs1_data", 32'(ID_rs1_data), mon_e.rs1);
      check(mon_e.tag, "rs2_data", 32'(ID_rs2_data), mon_e.rs2);
      check(mon_e.tag, "wb_data",  32'(wb_data),     mon_e.wbd);
      check(mon_e.tag, "wb_fire",  32'(wb_fire),     mon_e.fire);
      check(mon_e.tag, "wb_count", 32'(wb_count),    mon_e.cnt);
      check(mon_e.tag, "wb_err",   32'(wb_err),      mon_e.err);
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);

    // Everything reads zero after reset, including out-of-range indices.
    for (int i = 0; i < 10; i++) step("reset_read", 1, 0, 0, 0, 0, 0, i, (i + 3) % 10);

    // r3 write with bypass, then from the array; ALU then memory source.
    step("w_r3_alu", 1, 1, 0, 'hC3, 'h5A, 3, 3, 3);
    step("r3_alu",   1, 0, 0, 0, 0, 0, 3, 3);
    step("w_r3_mem", 1, 1, 1, 'hC3, 'h5A, 3, 3, 2);
    step("r3_mem",   1, 0, 0, 0, 0, 0, 3, 2);

    // Out-of-range write: sticky error, no array change, reads of 8 are zero.
    step("w_oob", 1, 1, 0, 0, 'h77, 8, 8, 0);
    for (int i = 0; i < 10; i++) step("oob_hold", 1, 0, 0, 0, 0, 0, 8, i % NREGS);

    // Reset beats a simultaneous write; reads show stored data meanwhile.
    step("w_r5",       1, 1, 0, 0, 'h11, 5, 5, 5);
    step("rst_w_r5",   0, 1, 0, 0, 'hFF, 5, 5, 5);
    step("r5_post_rst", 1, 0, 0, 0, 0, 0, 5, 5);

    // r0: hardwired zero only with the optional feature.
    step("w_r0",   1, 1, 0, 0, 'h12, 0, 0, 0);
    step("r0_read", 1, 0, 0, 0, 0, 0, 0, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step("random", $urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255),
           rand_addr(), rand_addr(), rand_addr());
    end

    // Counter saturation: more commits than the counter can hold.
    step("sat_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) begin
      step("saturate", 1, 1, $urandom_range(0, 1), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(1, NREGS - 1),
           $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1));
    end
    for (int i = 0; i < 4; i++) step("sat_hold", 1, 0, 0, 0, 0, 0, i, i + 4);

    repeat (2) @(posedge clk);
    check("end", "queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
